// File: rtl/fsm_refund_param.sv
// Vending controller: half-yuan credit against a parameter price, with change,
// cancel/full refund, stock tracking and a sold-out mode that bounces coins.
module fsm_refund_param #(
    parameter int PRICE      = 5,
    parameter int MONEY_W    = 3,
    parameter int STOCK_INIT = 8,
    parameter int STOCK_W    = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               pi_money_one,
    input  logic               pi_money_half,
    input  logic               pi_cancel,
    input  logic               pi_refill,
    output logic               po_cola,
    output logic [MONEY_W-1:0] po_money,
    output logic [MONEY_W-1:0] po_credit,
    output logic               po_empty
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_EMPTY = 2'd2
    } state_t;

    localparam logic [MONEY_W:0]   L_PRICE = (MONEY_W+1)'(PRICE);
    localparam logic [STOCK_W-1:0] L_INIT  = STOCK_W'(STOCK_INIT);
    localparam logic [STOCK_W-1:0] L_ONE   = STOCK_W'(1);

    state_t               r_state;
    logic [MONEY_W-1:0]   r_credit;
    logic [STOCK_W-1:0]   r_stock;
    logic                 r_cola;
    logic [MONEY_W-1:0]   r_money;
    logic                 r_empty;

    state_t               w_next_state;
    logic [MONEY_W-1:0]   w_next_credit;
    logic [STOCK_W-1:0]   w_next_stock;
    logic                 w_next_cola;
    logic [MONEY_W-1:0]   w_next_money;

    logic [1:0]           w_coin;
    logic [MONEY_W:0]     w_sum;
    logic [MONEY_W:0]     w_change;
    logic                 w_reach;

    // {one, half} is already 2*one + half
    assign w_coin   = {pi_money_one, pi_money_half};
    assign w_sum    = {1'b0, r_credit} + {{(MONEY_W-1){1'b0}}, w_coin};
    assign w_change = w_sum - L_PRICE;
    assign w_reach  = (w_sum >= L_PRICE);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state  <= S_IDLE;
            r_credit <= '0;
            r_stock  <= L_INIT;
            r_cola   <= 1'b0;
            r_money  <= '0;
            r_empty  <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_credit <= w_next_credit;
            r_stock  <= w_next_stock;
            r_cola   <= w_next_cola;
            r_money  <= w_next_money;
            r_empty  <= (w_next_state == S_EMPTY);
        end
    end

    // A refill in the selling cycle reloads stock, so it never empties
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_ACC: begin
                if (pi_cancel) begin
                    w_next_state = S_IDLE;
                end else if (w_reach) begin
                    if ((r_stock == L_ONE) && !pi_refill) begin
                        w_next_state = S_EMPTY;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end else if (w_sum != '0) begin
                    w_next_state = S_ACC;
                end
            end
            S_EMPTY: begin
                if (pi_refill) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_next_credit = r_credit;
        w_next_stock  = r_stock;
        w_next_cola   = 1'b0;
        w_next_money  = '0;
        if (r_state == S_EMPTY) begin
            w_next_credit = '0;
            w_next_money  = {{(MONEY_W-2){1'b0}}, w_coin};
        end else if (pi_cancel) begin
            w_next_credit = '0;
            w_next_money  = w_sum[MONEY_W-1:0];
        end else if (w_reach) begin
            w_next_credit = '0;
            w_next_cola   = 1'b1;
            w_next_money  = w_change[MONEY_W-1:0];
            w_next_stock  = r_stock - L_ONE;
        end else begin
            w_next_credit = w_sum[MONEY_W-1:0];
        end
        if (pi_refill) begin
            w_next_stock = L_INIT;
        end
    end

    assign po_cola   = r_cola;
    assign po_money  = r_money;
    assign po_credit = r_credit;
    assign po_empty  = r_empty;

endmodule

// File: tb/tb_fsm_refund_param.sv
// Directed bench: default instance driven from a vector table, a
// single-stock instance plus reset/stock corner sequences by hand.
module tb_fsm_refund_param;

    logic       clk;
    logic       rst_n;
    logic       a_one, a_half, a_cancel, a_refill;
    logic       a_cola, a_empty;
    logic [2:0] a_money, a_credit;
    logic       b_one, b_half, b_cancel, b_refill;
    logic       b_cola, b_empty;
    logic [2:0] b_money, b_credit;

    int checks = 0;
    int errors = 0;

    fsm_refund_param dut (
        .sys_clk       (clk),
        .sys_rst_n     (rst_n),
        .pi_money_one  (a_one),
        .pi_money_half (a_half),
        .pi_cancel     (a_cancel),
        .pi_refill     (a_refill),
        .po_cola       (a_cola),
        .po_money      (a_money),
        .po_credit     (a_credit),
        .po_empty      (a_empty)
    );

    fsm_refund_param #(
        .PRICE(5), .MONEY_W(3), .STOCK_INIT(1), .STOCK_W(2)
    ) dut1 (
        .sys_clk       (clk),
        .sys_rst_n     (rst_n),
        .pi_money_one  (b_one),
        .pi_money_half (b_half),
        .pi_cancel     (b_cancel),
        .pi_refill     (b_refill),
        .po_cola       (b_cola),
        .po_money      (b_money),
        .po_credit     (b_credit),
        .po_empty      (b_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string nm;
        logic  one, half, cancel, refill;
        int    cola, money, credit, empty;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string nm, logic o, logic h, logic c,
                                logic r, int ec, int em, int ecr, int ee);
        vec_t v;
        v.nm = nm; v.one = o; v.half = h; v.cancel = c; v.refill = r;
        v.cola = ec; v.money = em; v.credit = ecr; v.empty = ee;
        return v;
    endfunction

    task automatic cmp(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic chk(bit which, string nm, int ec, int em, int ecr, int ee);
        if (!which) begin
            cmp({nm, ".cola"}, int'(a_cola), ec);
            cmp({nm, ".money"}, int'(a_money), em);
            cmp({nm, ".credit"}, int'(a_credit), ecr);
            cmp({nm, ".empty"}, int'(a_empty), ee);
        end else begin
            cmp({nm, ".cola"}, int'(b_cola), ec);
            cmp({nm, ".money"}, int'(b_money), em);
            cmp({nm, ".credit"}, int'(b_credit), ecr);
            cmp({nm, ".empty"}, int'(b_empty), ee);
        end
    endtask

    task automatic drv(bit which, logic o, logic h, logic c, logic r);
        if (!which) begin
            a_one = o; a_half = h; a_cancel = c; a_refill = r;
        end else begin
            b_one = o; b_half = h; b_cancel = c; b_refill = r;
        end
        @(posedge clk);
        #1;
        a_one = 0; a_half = 0; a_cancel = 0; a_refill = 0;
        b_one = 0; b_half = 0; b_cancel = 0; b_refill = 0;
    endtask

    task automatic sale(bit which, string nm, int ee);
        drv(which, 1, 0, 0, 0);
        drv(which, 1, 0, 0, 0);
        drv(which, 0, 1, 0, 0);
        chk(which, nm, 1, 0, 0, ee);
    endtask

    initial begin
        a_one = 0; a_half = 0; a_cancel = 0; a_refill = 0;
        b_one = 0; b_half = 0; b_cancel = 0; b_refill = 0;
        rst_n = 0;

        tbl.push_back(mk("h1", 0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk("h2", 0, 1, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk("h3", 0, 1, 0, 0, 0, 0, 3, 0));
        tbl.push_back(mk("h4", 0, 1, 0, 0, 0, 0, 4, 0));
        tbl.push_back(mk("h5", 0, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("o1", 1, 0, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk("o2", 1, 0, 0, 0, 0, 0, 4, 0));
        tbl.push_back(mk("o3", 1, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk("oo_a", 1, 0, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk("oo_b", 1, 0, 0, 0, 0, 0, 4, 0));
        tbl.push_back(mk("both7", 1, 1, 0, 0, 1, 2, 0, 0));
        tbl.push_back(mk("cx_o", 1, 0, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk("cx_h", 0, 1, 0, 0, 0, 0, 3, 0));
        tbl.push_back(mk("cancel_h", 0, 1, 1, 0, 0, 4, 0, 0));
        tbl.push_back(mk("cancel0", 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("oh_a", 1, 1, 0, 0, 0, 0, 3, 0));
        tbl.push_back(mk("oh_b", 1, 1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk("refill_o", 1, 0, 0, 1, 0, 0, 2, 0));
        tbl.push_back(mk("oh_vend", 1, 1, 0, 0, 1, 0, 0, 0));

        #3;
        chk(0, "rst_a", 0, 0, 0, 0);
        chk(1, "rst_b", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // single-stock instance
        sale(1, "b_sale1", 1);
        drv(1, 1, 0, 0, 0);
        chk(1, "b_bounce", 0, 2, 0, 1);
        drv(1, 0, 0, 0, 1);
        chk(1, "b_refill", 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drv(1, 0, 1, 0, 0);
        chk(1, "b_h4", 0, 0, 4, 0);
        drv(1, 0, 1, 0, 0);
        chk(1, "b_h5", 1, 0, 0, 1);
        drv(1, 0, 0, 0, 1);
        chk(1, "b_refill2", 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drv(1, 0, 1, 0, 0);
        drv(1, 0, 1, 0, 1);
        chk(1, "b_vend_refill", 1, 0, 0, 0);
        sale(1, "b_sale3", 1);

        // default instance, vector table
        foreach (tbl[i]) begin
            drv(0, tbl[i].one, tbl[i].half, tbl[i].cancel, tbl[i].refill);
            chk(0, tbl[i].nm, tbl[i].cola, tbl[i].money,
                tbl[i].credit, tbl[i].empty);
        end

        // stock was reloaded to 8 then one sold: 7 left
        for (int i = 0; i < 6; i++) sale(0, "a_stock", 0);
        sale(0, "a_last", 1);
        drv(0, 0, 1, 1, 0);
        chk(0, "e_cancel_h", 0, 1, 0, 1);
        drv(0, 1, 1, 0, 0);
        chk(0, "e_both", 0, 3, 0, 1);
        drv(0, 0, 0, 0, 0);
        chk(0, "e_idle", 0, 0, 0, 1);
        drv(0, 1, 0, 0, 1);
        chk(0, "e_refill_o", 0, 2, 0, 0);
        sale(0, "a_after_refill", 0);
        drv(0, 0, 1, 0, 0);
        drv(0, 1, 0, 0, 0);
        chk(0, "pre_rst", 0, 0, 3, 0);

        #3;
        rst_n = 0;
        #1;
        chk(0, "async_rst", 0, 0, 0, 0);
        #1;
        rst_n = 1;
        @(posedge clk);
        #1;
        chk(0, "post_rst", 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) sale(0, "r_stock", 0);
        sale(0, "r_last", 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
